// File: rtl/main_memory_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (IF, DM) and MAIN_MEMORY.
// slave  : the arbiter's view.
// master : the environment's view (requesters plus memory).
`timescale 1ns/1ps
interface main_memory_arbiter_if #(
    parameter int DATAWIDTH_BUS = 32
);
    // instruction-fetch requester
    logic                     IF_Req_In;
    logic [DATAWIDTH_BUS-1:0] IF_Addr_InBus;
    logic                     IF_Ack_Out;
    logic [DATAWIDTH_BUS-1:0] IF_Data_OutBus;
    // data-access requester
    logic                     DM_Req_In;
    logic                     DM_Wr_In;
    logic [DATAWIDTH_BUS-1:0] DM_Addr_InBus;
    logic [DATAWIDTH_BUS-1:0] DM_WData_InBus;
    logic                     DM_Ack_Out;
    logic [DATAWIDTH_BUS-1:0] DM_Data_OutBus;
    // memory port
    logic [DATAWIDTH_BUS-1:0] MEM_A_OutBus;
    logic [DATAWIDTH_BUS-1:0] MEM_B_OutBus;
    logic                     MEM_RD_Out;
    logic                     MEM_WRMain_Out;
    logic                     MEM_ACK_In;
    logic [DATAWIDTH_BUS-1:0] MEM_Data_InBus;
    // status
    logic                     Err_Out;
    logic                     Busy_Out;

    modport slave (
        input  IF_Req_In, IF_Addr_InBus,
        output IF_Ack_Out, IF_Data_OutBus,
        input  DM_Req_In, DM_Wr_In, DM_Addr_InBus, DM_WData_InBus,
        output DM_Ack_Out, DM_Data_OutBus,
        output MEM_A_OutBus, MEM_B_OutBus, MEM_RD_Out, MEM_WRMain_Out,
        input  MEM_ACK_In, MEM_Data_InBus,
        output Err_Out, Busy_Out
    );

    modport master (
        output IF_Req_In, IF_Addr_InBus,
        input  IF_Ack_Out, IF_Data_OutBus,
        output DM_Req_In, DM_Wr_In, DM_Addr_InBus, DM_WData_InBus,
        input  DM_Ack_Out, DM_Data_OutBus,
        input  MEM_A_OutBus, MEM_B_OutBus, MEM_RD_Out, MEM_WRMain_Out,
        output MEM_ACK_In, MEM_Data_InBus,
        input  Err_Out, Busy_Out
    );
endinterface

// File: rtl/main_memory_arbiter.sv
// Round-robin arbiter sharing one MAIN_MEMORY port between IF and DM.
// IDLE -> ISSUE (strobes up, wait ACK or timeout) -> DONE (1-cycle Ack) -> IDLE.
// Every output is a flop loaded from the next-state view, so strobes appear
// the cycle after a request is sampled and nothing is combinational from inputs.
`timescale 1ns/1ps
module main_memory_arbiter #(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TO_WIDTH       = 4
) (
    input  logic                  MAIN_MEMORY_ARBITER_CLOCK_50,
    input  logic                  MAIN_MEMORY_ARBITER_ResetInLow_In,
    main_memory_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES);

    logic clk, rst_n;
    assign clk   = MAIN_MEMORY_ARBITER_CLOCK_50;
    assign rst_n = MAIN_MEMORY_ARBITER_ResetInLow_In;

    // control state
    state_t              state_q, state_d;
    logic [TO_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic                last_dm_q, last_dm_d;   // 1: DM was granted last
    logic                gnt_dm_q, gnt_dm_d;     // current grantee (1: DM)
    logic                wr_q, wr_d;             // current access is a write
    logic                err_hit;

    // registered outputs
    logic [DATAWIDTH_BUS-1:0] a_q, a_d, b_q, b_d;
    logic [DATAWIDTH_BUS-1:0] if_data_q, if_data_d, dm_data_q, dm_data_d, rdata;
    logic rd_q, rd_d, wrs_q, wrs_d;
    logic if_ack_q, if_ack_d, dm_ack_q, dm_ack_d, err_q, err_d, busy_q, busy_d;

    assign cnt_inc = cnt_q + TO_WIDTH'(1);

    // State register: control flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            last_dm_q <= 1'b1;     // IF wins the first tie
            gnt_dm_q  <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_dm_q <= last_dm_d;
            gnt_dm_q  <= gnt_dm_d;
            wr_q      <= wr_d;
        end
    end

    // Next state: arbitration, timeout counting, ACK beats timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_dm_d = last_dm_q;
        gnt_dm_d  = gnt_dm_q;
        wr_d      = wr_q;
        err_hit   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.IF_Req_In || bus.DM_Req_In) begin
                    gnt_dm_d  = bus.DM_Req_In && (!bus.IF_Req_In || !last_dm_q);
                    last_dm_d = gnt_dm_d;
                    wr_d      = gnt_dm_d && bus.DM_Wr_In;   // IF is read-only
                    cnt_d     = '0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_inc;
                if (bus.MEM_ACK_In) begin
                    state_d = S_DONE;
                end else if (cnt_inc == TO_LIMIT) begin
                    state_d = S_DONE;
                    err_hit = 1'b1;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: next values of the output flops, derived from the next state.
    always_comb begin
        a_d   = '0;
        b_d   = '0;
        rd_d  = (state_d == S_ISSUE) && !wr_d;
        wrs_d = (state_d == S_ISSUE) && wr_d;
        if (state_d == S_ISSUE) begin
            if (state_q == S_IDLE) begin
                a_d = gnt_dm_d ? bus.DM_Addr_InBus : bus.IF_Addr_InBus;
                b_d = wr_d ? bus.DM_WData_InBus : '0;
            end else begin
                a_d = a_q;
                b_d = b_q;
            end
        end
        // only consumed on the ISSUE->DONE edge; timeout and writes return 0
        rdata     = (bus.MEM_ACK_In && !wr_q) ? bus.MEM_Data_InBus : '0;
        if_ack_d  = (state_d == S_DONE) && !gnt_dm_d;
        dm_ack_d  = (state_d == S_DONE) && gnt_dm_d;
        if_data_d = if_ack_d ? rdata : '0;
        dm_data_d = dm_ack_d ? rdata : '0;
        err_d     = (state_d == S_DONE) && err_hit;
        busy_d    = (state_d != S_IDLE);
    end

    // Output flops: reset drops strobes and Ack immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0; b_q <= '0; rd_q <= 1'b0; wrs_q <= 1'b0;
            if_ack_q <= 1'b0; dm_ack_q <= 1'b0;
            if_data_q <= '0; dm_data_q <= '0;
            err_q <= 1'b0; busy_q <= 1'b0;
        end else begin
            a_q <= a_d; b_q <= b_d; rd_q <= rd_d; wrs_q <= wrs_d;
            if_ack_q <= if_ack_d; dm_ack_q <= dm_ack_d;
            if_data_q <= if_data_d; dm_data_q <= dm_data_d;
            err_q <= err_d; busy_q <= busy_d;
        end
    end

    assign bus.MEM_A_OutBus   = a_q;
    assign bus.MEM_B_OutBus   = b_q;
    assign bus.MEM_RD_Out     = rd_q;
    assign bus.MEM_WRMain_Out = wrs_q;
    assign bus.IF_Ack_Out     = if_ack_q;
    assign bus.DM_Ack_Out     = dm_ack_q;
    assign bus.IF_Data_OutBus = if_data_q;
    assign bus.DM_Data_OutBus = dm_data_q;
    assign bus.Err_Out        = err_q;
    assign bus.Busy_Out       = busy_q;
endmodule

// File: tb/tb_main_memory_arbiter.sv
// Self-checking bench for main_memory_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_main_memory_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_ack = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   m_last_dm = 1'b1;   // model: last grantee was DM

    main_memory_arbiter_if #(.DATAWIDTH_BUS(32)) bus ();

    main_memory_arbiter #(.DATAWIDTH_BUS(32), .TIMEOUT_CYCLES(15), .TO_WIDTH(4)) dut (
        .MAIN_MEMORY_ARBITER_CLOCK_50      (clk),
        .MAIN_MEMORY_ARBITER_ResetInLow_In (rst_n),
        .bus                               (bus)
    );

    always #5 clk = ~clk;

    // memory model: known words at a few addresses, hash elsewhere; junk without ACK
    function automatic logic [31:0] memfn(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h9080200A;
            32'd3:   return 32'h8E814006;
            32'd7:   return 32'h12BFFFFC;
            default: return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
        endcase
    endfunction

    assign bus.MEM_ACK_In     = mem_ack;
    assign bus.MEM_Data_InBus = mem_ack ? memfn(bus.MEM_A_OutBus) : 32'hBADC0DE0;

    task automatic reset_pulse();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_last_dm = 1'b1;
    endtask

    task automatic new_dm();
        bus.DM_Req_In      = 1'b1;
        bus.DM_Addr_InBus  = $urandom_range(0, 63);
        bus.DM_Wr_In       = 1'($urandom_range(0, 1));
        bus.DM_WData_InBus = $urandom();
    endtask

    task automatic test_reset();
        #2;
        checks++; if ({bus.IF_Ack_Out, bus.DM_Ack_Out, bus.MEM_RD_Out, bus.MEM_WRMain_Out, bus.Err_Out, bus.Busy_Out} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b exp 000000", {bus.IF_Ack_Out, bus.DM_Ack_Out, bus.MEM_RD_Out, bus.MEM_WRMain_Out, bus.Err_Out, bus.Busy_Out}); end
        checks++; if ({bus.IF_Data_OutBus, bus.DM_Data_OutBus, bus.MEM_A_OutBus, bus.MEM_B_OutBus} !== 128'b0) begin errors++; $display("FAIL reset_buses got %h exp 0", {bus.IF_Data_OutBus, bus.DM_Data_OutBus, bus.MEM_A_OutBus, bus.MEM_B_OutBus}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_last_dm = 1'b1;
    endtask

    task automatic test_latency();
        mem_ack = 1'b1;
        bus.IF_Req_In = 1'b1; bus.IF_Addr_InBus = 32'd3;
        @(posedge clk); #1;
        checks++; if (bus.MEM_RD_Out !== 1'b1 || bus.MEM_WRMain_Out !== 1'b0) begin errors++; $display("FAIL lat_strobe got rd=%b wr=%b exp rd=1 wr=0", bus.MEM_RD_Out, bus.MEM_WRMain_Out); end
        checks++; if (bus.MEM_A_OutBus !== 32'd3 || bus.IF_Ack_Out !== 1'b0) begin errors++; $display("FAIL lat_issue got a=%h ack=%b exp a=3 ack=0", bus.MEM_A_OutBus, bus.IF_Ack_Out); end
        @(posedge clk); #1;
        checks++; if (bus.IF_Ack_Out !== 1'b1 || bus.IF_Data_OutBus !== 32'h8E814006) begin errors++; $display("FAIL lat_ack got ack=%b data=%h exp ack=1 data=8e814006", bus.IF_Ack_Out, bus.IF_Data_OutBus); end
        checks++; if (bus.MEM_RD_Out !== 1'b0 || bus.Err_Out !== 1'b0 || bus.Busy_Out !== 1'b1) begin errors++; $display("FAIL lat_done got rd=%b err=%b busy=%b exp 0 0 1", bus.MEM_RD_Out, bus.Err_Out, bus.Busy_Out); end
        bus.IF_Req_In = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.IF_Ack_Out !== 1'b0 || bus.IF_Data_OutBus !== 32'd0 || bus.Busy_Out !== 1'b0) begin errors++; $display("FAIL lat_idle got ack=%b data=%h busy=%b exp 0 0 0", bus.IF_Ack_Out, bus.IF_Data_OutBus, bus.Busy_Out); end
        m_last_dm = 1'b0;
    endtask

    task automatic test_tie();
        reset_pulse();
        mem_ack = 1'b1;
        bus.IF_Req_In = 1'b1; bus.IF_Addr_InBus = 32'd0;
        bus.DM_Req_In = 1'b1; bus.DM_Wr_In = 1'b0; bus.DM_Addr_InBus = 32'd7;
        @(posedge clk); #1;
        checks++; if (bus.MEM_A_OutBus !== 32'd0 || bus.MEM_RD_Out !== 1'b1) begin errors++; $display("FAIL tie_first got a=%h rd=%b exp a=0 rd=1", bus.MEM_A_OutBus, bus.MEM_RD_Out); end
        @(posedge clk); #1;
        checks++; if (bus.IF_Ack_Out !== 1'b1 || bus.DM_Ack_Out !== 1'b0 || bus.IF_Data_OutBus !== 32'h9080200A) begin errors++; $display("FAIL tie_if_ack got if=%b dm=%b data=%h exp 1 0 9080200a", bus.IF_Ack_Out, bus.DM_Ack_Out, bus.IF_Data_OutBus); end
        bus.IF_Req_In = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.IF_Ack_Out !== 1'b0 || bus.Busy_Out !== 1'b0) begin errors++; $display("FAIL tie_pulse got ack=%b busy=%b exp 0 0", bus.IF_Ack_Out, bus.Busy_Out); end
        @(posedge clk); #1;
        checks++; if (bus.MEM_A_OutBus !== 32'd7 || bus.MEM_RD_Out !== 1'b1) begin errors++; $display("FAIL tie_second got a=%h rd=%b exp a=7 rd=1", bus.MEM_A_OutBus, bus.MEM_RD_Out); end
        @(posedge clk); #1;
        checks++; if (bus.DM_Ack_Out !== 1'b1 || bus.IF_Ack_Out !== 1'b0 || bus.DM_Data_OutBus !== 32'h12BFFFFC) begin errors++; $display("FAIL tie_dm_ack got dm=%b if=%b data=%h exp 1 0 12bffffc", bus.DM_Ack_Out, bus.IF_Ack_Out, bus.DM_Data_OutBus); end
        bus.DM_Req_In = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.DM_Ack_Out !== 1'b0 || bus.DM_Data_OutBus !== 32'd0) begin errors++; $display("FAIL tie_dm_fall got ack=%b data=%h exp 0 0", bus.DM_Ack_Out, bus.DM_Data_OutBus); end
        m_last_dm = 1'b1;
    endtask

    task automatic test_write();
        mem_ack = 1'b1;
        bus.DM_Req_In = 1'b1; bus.DM_Wr_In = 1'b1;
        bus.DM_Addr_InBus = 32'h20; bus.DM_WData_InBus = 32'hDEADBEEF;
        @(posedge clk); #1;
        checks++; if (bus.MEM_WRMain_Out !== 1'b1 || bus.MEM_RD_Out !== 1'b0) begin errors++; $display("FAIL wr_strobe got wr=%b rd=%b exp 1 0", bus.MEM_WRMain_Out, bus.MEM_RD_Out); end
        checks++; if (bus.MEM_A_OutBus !== 32'h20 || bus.MEM_B_OutBus !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_bus got a=%h b=%h exp 20 deadbeef", bus.MEM_A_OutBus, bus.MEM_B_OutBus); end
        @(posedge clk); #1;
        checks++; if (bus.DM_Ack_Out !== 1'b1 || bus.DM_Data_OutBus !== 32'd0 || bus.MEM_WRMain_Out !== 1'b0) begin errors++; $display("FAIL wr_ack got ack=%b data=%h wr=%b exp 1 0 0", bus.DM_Ack_Out, bus.DM_Data_OutBus, bus.MEM_WRMain_Out); end
        bus.DM_Req_In = 1'b0; bus.DM_Wr_In = 1'b0;
        @(posedge clk); #1;
        m_last_dm = 1'b1;
    endtask

    task automatic test_timeout();
        int n = 0;
        bit acked = 1'b0;
        mem_ack = 1'b0;
        bus.DM_Req_In = 1'b1; bus.DM_Wr_In = 1'b0; bus.DM_Addr_InBus = 32'd5;
        for (int c = 0; c < 40 && !acked; c++) begin
            @(posedge clk); #1;
            if (bus.MEM_RD_Out === 1'b1) n++;
            if (bus.DM_Ack_Out === 1'b1) acked = 1'b1;
        end
        checks++; if (!acked) begin errors++; $display("FAIL to_ack got no DM_Ack in 40 cycles exp ack"); end
        checks++; if (n != 15) begin errors++; $display("FAIL to_cycles got %0d exp 15", n); end
        checks++; if (bus.Err_Out !== 1'b1 || bus.DM_Data_OutBus !== 32'd0) begin errors++; $display("FAIL to_err got err=%b data=%h exp 1 0", bus.Err_Out, bus.DM_Data_OutBus); end
        bus.DM_Req_In = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.Err_Out !== 1'b0) begin errors++; $display("FAIL to_err_pulse got %b exp 0", bus.Err_Out); end
        mem_ack = 1'b1;
        bus.DM_Req_In = 1'b1; bus.DM_Addr_InBus = 32'd7;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (bus.DM_Ack_Out !== 1'b1 || bus.Err_Out !== 1'b0 || bus.DM_Data_OutBus !== 32'h12BFFFFC) begin errors++; $display("FAIL to_next got ack=%b err=%b data=%h exp 1 0 12bffffc", bus.DM_Ack_Out, bus.Err_Out, bus.DM_Data_OutBus); end
        bus.DM_Req_In = 1'b0;
        @(posedge clk); #1;
        m_last_dm = 1'b1;
    endtask

    task automatic test_reset_mid();
        mem_ack = 1'b0;
        bus.IF_Req_In = 1'b1; bus.IF_Addr_InBus = 32'd3;
        @(posedge clk); #1;
        checks++; if (bus.MEM_RD_Out !== 1'b1) begin errors++; $display("FAIL rm_issue got rd=%b exp 1", bus.MEM_RD_Out); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.MEM_RD_Out !== 1'b0 || bus.Busy_Out !== 1'b0 || bus.IF_Ack_Out !== 1'b0) begin errors++; $display("FAIL rm_async got rd=%b busy=%b ack=%b exp 0 0 0", bus.MEM_RD_Out, bus.Busy_Out, bus.IF_Ack_Out); end
        bus.DM_Req_In = 1'b1; bus.DM_Wr_In = 1'b0; bus.DM_Addr_InBus = 32'd7;
        @(posedge clk); #1;
        checks++; if (bus.IF_Ack_Out !== 1'b0 || bus.Err_Out !== 1'b0) begin errors++; $display("FAIL rm_noack got ack=%b err=%b exp 0 0", bus.IF_Ack_Out, bus.Err_Out); end
        rst_n = 1'b1; m_last_dm = 1'b1;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.MEM_A_OutBus !== 32'd3 || bus.MEM_RD_Out !== 1'b1) begin errors++; $display("FAIL rm_regrant got a=%h rd=%b exp 3 1", bus.MEM_A_OutBus, bus.MEM_RD_Out); end
        @(posedge clk); #1;
        checks++; if (bus.IF_Ack_Out !== 1'b1 || bus.Err_Out !== 1'b0) begin errors++; $display("FAIL rm_if_ack got ack=%b err=%b exp 1 0", bus.IF_Ack_Out, bus.Err_Out); end
        bus.IF_Req_In = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.DM_Ack_Out !== 1'b1 || bus.DM_Data_OutBus !== 32'h12BFFFFC) begin errors++; $display("FAIL rm_dm_ack got ack=%b data=%h exp 1 12bffffc", bus.DM_Ack_Out, bus.DM_Data_OutBus); end
        bus.DM_Req_In = 1'b0;
        @(posedge clk); #1;
        m_last_dm = 1'b1;
    endtask

    task automatic test_round_robin();
        bit order[$];
        bit exp_dm;
        reset_pulse();
        mem_ack = 1'b1;
        bus.IF_Req_In = 1'b1; bus.IF_Addr_InBus = 32'd0;
        bus.DM_Req_In = 1'b1; bus.DM_Wr_In = 1'b1; bus.DM_Addr_InBus = 32'h40; bus.DM_WData_InBus = 32'h1234;
        for (int c = 0; c < 60 && order.size() < 6; c++) begin
            @(posedge clk); #1;
            checks++; if (bus.MEM_RD_Out === 1'b1 && bus.MEM_WRMain_Out === 1'b1) begin errors++; $display("FAIL rr_both_strobes got rd=1 wr=1 exp not both"); end
            if (bus.IF_Ack_Out === 1'b1) order.push_back(1'b0);
            if (bus.DM_Ack_Out === 1'b1) order.push_back(1'b1);
        end
        bus.IF_Req_In = 1'b0; bus.DM_Req_In = 1'b0; bus.DM_Wr_In = 1'b0;
        checks++; if (order.size() != 6) begin errors++; $display("FAIL rr_count got %0d exp 6", order.size()); end
        foreach (order[i]) begin
            exp_dm = !m_last_dm; m_last_dm = exp_dm;
            checks++; if (order[i] !== exp_dm) begin errors++; $display("FAIL rr_order[%0d] got dm=%b exp dm=%b", i, order[i], exp_dm); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit gdm, ew, ex_err;
        logic [31:0] ea, eb, ed, gd, od;
        int k;
        for (int t = 0; t < 60; t++) begin
            if (!bus.IF_Req_In && $urandom_range(0, 1) == 1) begin
                bus.IF_Req_In = 1'b1; bus.IF_Addr_InBus = $urandom_range(0, 63);
            end
            if (!bus.DM_Req_In && $urandom_range(0, 1) == 1) new_dm();
            if (!bus.IF_Req_In && !bus.DM_Req_In) new_dm();
            gdm = bus.DM_Req_In && (!bus.IF_Req_In || !m_last_dm);
            m_last_dm = gdm;
            ew = gdm && bus.DM_Wr_In;
            ea = gdm ? bus.DM_Addr_InBus : bus.IF_Addr_InBus;
            eb = bus.DM_WData_InBus;
            case ($urandom_range(0, 5))
                0:       begin k = 15; ex_err = 1'b1; end
                1:       begin k = 15; ex_err = 1'b0; end
                default: begin k = $urandom_range(1, 5); ex_err = 1'b0; end
            endcase
            ed = (ew || ex_err) ? 32'd0 : memfn(ea);
            @(posedge clk); #1;
            for (int i = 0; i < k; i++) begin
                checks++; if (bus.MEM_RD_Out !== !ew || bus.MEM_WRMain_Out !== ew) begin errors++; $display("FAIL rnd_strobe t=%0d i=%0d got rd=%b wr=%b exp rd=%b wr=%b", t, i, bus.MEM_RD_Out, bus.MEM_WRMain_Out, !ew, ew); end
                checks++; if (bus.MEM_A_OutBus !== ea || (ew && bus.MEM_B_OutBus !== eb)) begin errors++; $display("FAIL rnd_bus t=%0d got a=%h b=%h exp a=%h b=%h", t, bus.MEM_A_OutBus, bus.MEM_B_OutBus, ea, eb); end
                checks++; if (bus.Busy_Out !== 1'b1 || bus.IF_Ack_Out !== 1'b0 || bus.DM_Ack_Out !== 1'b0 || bus.Err_Out !== 1'b0) begin errors++; $display("FAIL rnd_issue t=%0d got busy=%b ifa=%b dma=%b err=%b exp 1 0 0 0", t, bus.Busy_Out, bus.IF_Ack_Out, bus.DM_Ack_Out, bus.Err_Out); end
                if (i == 0 && $urandom_range(0, 3) == 0) begin
                    if (gdm) bus.DM_Req_In = 1'b0; else bus.IF_Req_In = 1'b0;
                end
                mem_ack = !ex_err && (i == k - 1);
                @(posedge clk); #1;
            end
            mem_ack = 1'b0;
            gd = gdm ? bus.DM_Data_OutBus : bus.IF_Data_OutBus;
            od = gdm ? bus.IF_Data_OutBus : bus.DM_Data_OutBus;
            checks++; if (bus.IF_Ack_Out !== !gdm || bus.DM_Ack_Out !== gdm) begin errors++; $display("FAIL rnd_ack t=%0d got ifa=%b dma=%b exp ifa=%b dma=%b", t, bus.IF_Ack_Out, bus.DM_Ack_Out, !gdm, gdm); end
            checks++; if (gd !== ed || od !== 32'd0) begin errors++; $display("FAIL rnd_data t=%0d got %h/%h exp %h/0", t, gd, od, ed); end
            checks++; if (bus.Err_Out !== ex_err || bus.MEM_RD_Out !== 1'b0 || bus.MEM_WRMain_Out !== 1'b0) begin errors++; $display("FAIL rnd_done t=%0d got err=%b rd=%b wr=%b exp err=%b 0 0", t, bus.Err_Out, bus.MEM_RD_Out, bus.MEM_WRMain_Out, ex_err); end
            if (gdm) bus.DM_Req_In = 1'b0; else bus.IF_Req_In = 1'b0;
            @(posedge clk); #1;
            checks++; if (bus.Busy_Out !== 1'b0 || bus.IF_Ack_Out !== 1'b0 || bus.DM_Ack_Out !== 1'b0 || bus.Err_Out !== 1'b0 || bus.IF_Data_OutBus !== 32'd0 || bus.DM_Data_OutBus !== 32'd0) begin errors++; $display("FAIL rnd_idle t=%0d got busy=%b ifa=%b dma=%b err=%b", t, bus.Busy_Out, bus.IF_Ack_Out, bus.DM_Ack_Out, bus.Err_Out); end
        end
        bus.IF_Req_In = 1'b0; bus.DM_Req_In = 1'b0;
    endtask

    initial begin
        bus.IF_Req_In = 1'b0; bus.IF_Addr_InBus = '0;
        bus.DM_Req_In = 1'b0; bus.DM_Wr_In = 1'b0;
        bus.DM_Addr_InBus = '0; bus.DM_WData_InBus = '0;
        test_reset();
        test_latency();
        test_tie();
        test_write();
        test_timeout();
        test_reset_mid();
        test_round_robin();
        test_random();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule
